// File: rtl/fp_add_seq_if.sv
// Handshake/operand bus for the multi-cycle single-precision adder fp_add_seq.
// The master drives EN/start/operands; the slave (the adder) returns OUT_ADD/busy/done.
interface fp_add_seq_if;
    logic        EN;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] OUT_ADD;
    logic        busy;
    logic        done;

    modport master (output EN, start, A, B, input OUT_ADD, busy, done);
    modport slave  (input EN, start, A, B, output OUT_ADD, busy, done);
endinterface

// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle IEEE-754 single-precision adder (unpack, align, add, normalize, round, pack).
// Optional macro FADD_RNE_EN selects round-to-nearest-even; the default build truncates toward zero.
module fp_add_seq #(
    parameter int NORM_MAX = 26
) (
    input  logic        clk,
    input  logic        RST,
    fp_add_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, PACK} state_t;

    localparam logic [5:0]  NMAX = 6'(NORM_MAX);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t      state, state_n;
    logic [31:0] a_p0, b_p0, a_p0_n, b_p0_n;
    logic        sx_p1, sy_p1, sx_p1_n, sy_p1_n;
    logic [7:0]  ex_p1, ey_p1, ex_p1_n, ey_p1_n;
    logic [23:0] mx_p1, my_p1, mx_p1_n, my_p1_n;
    logic        spec_p1, spec_p1_n;
    logic [31:0] sval_p1, sval_p1_n;
    logic [26:0] yal_p2, yal_p2_n;
    logic [27:0] sum_p3, sum_p3_n;
    logic [9:0]  rexp_p3, rexp_p3_n;
    logic        rsign_p3, rsign_p3_n, zero_p3, zero_p3_n;
    logic [5:0]  cnt_p3, cnt_p3_n;
    logic [22:0] rmant_p4, rmant_p4_n;
    logic [31:0] out_q, pk;
    logic        done_q;

    logic [7:0]  ea, eb, d;
    logic [23:0] ma, mb;
    logic        za, zb, nan_a, nan_b, inf_a, inf_b, a_big, special;
    logic [31:0] sval;
    logic [26:0] ext, yal;
    logic [27:0] s, sh_s, sh_n;
    logic [9:0]  e_dec;
    logic [5:0]  cnt_inc;
    logic [24:0] rnd;

`ifdef FADD_RNE_EN
    function automatic logic [24:0] round_mant(input logic [26:0] v);
        logic inc;
        inc = v[2] & (v[1] | v[0] | v[3]);
        return {1'b0, v[26:3]} + {24'd0, inc};
    endfunction
`else
    function automatic logic [24:0] round_mant(input logic [23:0] m);
        return {1'b0, m};
    endfunction
`endif

    function automatic logic [31:0] pack_fp(input logic sg, input logic [9:0] e, input logic [22:0] m);
        if (e >= 10'd255) return {sg, 8'hFF, 23'd0};
        return {sg, e[7:0], m};
    endfunction

    always_comb begin
        ea      = a_p0[30:23];
        eb      = b_p0[30:23];
        za      = (ea == 8'd0);
        zb      = (eb == 8'd0);
        ma      = za ? 24'd0 : {1'b1, a_p0[22:0]};
        mb      = zb ? 24'd0 : {1'b1, b_p0[22:0]};
        nan_a   = (ea == 8'hFF) && (a_p0[22:0] != 23'd0);
        nan_b   = (eb == 8'hFF) && (b_p0[22:0] != 23'd0);
        inf_a   = (ea == 8'hFF) && (a_p0[22:0] == 23'd0);
        inf_b   = (eb == 8'hFF) && (b_p0[22:0] == 23'd0);
        a_big   = {ea, ma} >= {eb, mb};
        special = nan_a | nan_b | inf_a | inf_b | (za & zb);
        if (nan_a || nan_b || (inf_a && inf_b && (a_p0[31] != b_p0[31]))) sval = QNAN;
        else if (inf_a) sval = a_p0;
        else if (inf_b) sval = b_p0;
        else            sval = {a_p0[31] & b_p0[31], 31'd0};

        // Alignment keeps every bit shifted past R as a sticky OR in bit 0.
        d   = ex_p1 - ey_p1;
        ext = {my_p1, 3'b000};
        if (d >= 8'd27) yal = {26'd0, |my_p1};
        else            yal = (ext >> d) | {26'd0, |(ext & ~({27{1'b1}} << d))};

        s       = (sx_p1 == sy_p1) ? {1'b0, mx_p1, 3'b000} + {1'b0, yal_p2}
                                   : {1'b0, mx_p1, 3'b000} - {1'b0, yal_p2};
        sh_s    = s << 1;
        sh_n    = sum_p3 << 1;
        e_dec   = rexp_p3 - 10'd1;
        cnt_inc = cnt_p3 + 6'd1;
`ifdef FADD_RNE_EN
        rnd = round_mant(sum_p3[26:0]);
`else
        rnd = round_mant(sum_p3[26:3]);
`endif
        if (spec_p1)      pk = sval_p1;
        else if (zero_p3) pk = {rsign_p3, 31'd0};
        else              pk = pack_fp(rsign_p3, rexp_p3, rmant_p4);
    end

    always_comb begin
        state_n    = state;
        a_p0_n     = a_p0;
        b_p0_n     = b_p0;
        sx_p1_n    = sx_p1;
        sy_p1_n    = sy_p1;
        ex_p1_n    = ex_p1;
        ey_p1_n    = ey_p1;
        mx_p1_n    = mx_p1;
        my_p1_n    = my_p1;
        spec_p1_n  = spec_p1;
        sval_p1_n  = sval_p1;
        yal_p2_n   = yal_p2;
        sum_p3_n   = sum_p3;
        rexp_p3_n  = rexp_p3;
        rsign_p3_n = rsign_p3;
        zero_p3_n  = zero_p3;
        cnt_p3_n   = cnt_p3;
        rmant_p4_n = rmant_p4;
        case (state)
            IDLE: if (bus.start) begin
                a_p0_n  = bus.A;
                b_p0_n  = bus.B;
                state_n = UNPACK;
            end
            UNPACK: begin
                spec_p1_n = special;
                sval_p1_n = sval;
                sx_p1_n   = a_big ? a_p0[31] : b_p0[31];
                sy_p1_n   = a_big ? b_p0[31] : a_p0[31];
                ex_p1_n   = a_big ? ea : eb;
                ey_p1_n   = a_big ? eb : ea;
                mx_p1_n   = a_big ? ma : mb;
                my_p1_n   = a_big ? mb : ma;
                state_n   = special ? PACK : ALIGN;
            end
            ALIGN: begin
                yal_p2_n = yal;
                state_n  = ADD;
            end
            // ADD absorbs the first left shift so a one-position cancellation skips NORM.
            ADD: begin
                rsign_p3_n = sx_p1;
                rexp_p3_n  = {2'd0, ex_p1};
                zero_p3_n  = 1'b0;
                cnt_p3_n   = 6'd0;
                sum_p3_n   = s;
                if (s[27] || s == 28'd0) state_n = NORM;
                else if (s[26])          state_n = ROUND;
                else begin
                    sum_p3_n  = sh_s;
                    rexp_p3_n = {2'd0, ex_p1} - 10'd1;
                    if (ex_p1 == 8'd1) begin
                        zero_p3_n = 1'b1;
                        state_n   = PACK;
                    end else state_n = sh_s[26] ? ROUND : NORM;
                end
            end
            NORM: begin
                if (sum_p3[27]) begin
                    sum_p3_n  = {1'b0, sum_p3[27:2], sum_p3[1] | sum_p3[0]};
                    rexp_p3_n = rexp_p3 + 10'd1;
                    state_n   = ROUND;
                end else if (sum_p3 == 28'd0) begin
                    zero_p3_n  = 1'b1;
                    rsign_p3_n = 1'b0;
                    state_n    = PACK;
                end else begin
                    sum_p3_n  = sh_n;
                    rexp_p3_n = e_dec;
                    cnt_p3_n  = cnt_inc;
                    if (e_dec == 10'd0) begin
                        zero_p3_n = 1'b1;
                        state_n   = PACK;
                    end else if (sh_n[26]) state_n = ROUND;
                    else if (cnt_inc == NMAX) begin
                        zero_p3_n  = 1'b1;
                        rsign_p3_n = 1'b0;
                        state_n    = PACK;
                    end
                end
            end
            ROUND: begin
                if (rnd[24]) begin
                    rmant_p4_n = rnd[23:1];
                    rexp_p3_n  = rexp_p3 + 10'd1;
                end else rmant_p4_n = rnd[22:0];
                state_n = PACK;
            end
            PACK:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state  <= IDLE;
            done_q <= 1'b0;
            out_q  <= 32'd0;
        end else if (bus.EN) begin
            state  <= state_n;
            done_q <= (state == PACK);
            if (state == PACK) out_q <= pk;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.EN) begin
            a_p0     <= a_p0_n;
            b_p0     <= b_p0_n;
            sx_p1    <= sx_p1_n;
            sy_p1    <= sy_p1_n;
            ex_p1    <= ex_p1_n;
            ey_p1    <= ey_p1_n;
            mx_p1    <= mx_p1_n;
            my_p1    <= my_p1_n;
            spec_p1  <= spec_p1_n;
            sval_p1  <= sval_p1_n;
            yal_p2   <= yal_p2_n;
            sum_p3   <= sum_p3_n;
            rexp_p3  <= rexp_p3_n;
            rsign_p3 <= rsign_p3_n;
            zero_p3  <= zero_p3_n;
            cnt_p3   <= cnt_p3_n;
            rmant_p4 <= rmant_p4_n;
        end
    end

    assign bus.OUT_ADD = out_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq: hand-computed sums, latencies, EN stall, start-while-busy and reset abort.
module tb_fp_add_seq;
    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    fp_add_seq_if bus();
    fp_add_seq #(.NORM_MAX(26)) dut (.clk(clk), .RST(RST), .bus(bus));

    int n_vec = 0;
    int n_miss = 0;
    int restart_at = -1;
    int en_at = -1;
    int lat, bc, extra;
    logic [31:0] exp_rne;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // lat counts clock edges from the accepting edge to the edge that raises done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int l, output int busy_cnt);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        l = 0;
        busy_cnt = 0;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && l < 60) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            l++;
            bus.start = (l == restart_at);
            if (l == restart_at) begin
                bus.A = 32'h3F80_0000;
                bus.B = 32'h3F80_0000;
            end
            if (l == en_at) bus.EN = 1'b0;
            if (en_at >= 0 && l == en_at + 3) bus.EN = 1'b1;
        end
        bus.start = 1'b0;
    endtask

    task automatic do_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input int exp_lat);
        int l, bcount;
        run_op(a, b, l, bcount);
        check({tag, " result"}, bus.OUT_ADD, res);
        check({tag, " latency"}, 32'(l), 32'(exp_lat));
        @(negedge clk);
        check({tag, " done cleared"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
`ifdef FADD_RNE_EN
        exp_rne = 32'h3F80_0001;
`else
        exp_rne = 32'h3F80_0000;
`endif
        RST = 1'b1;
        bus.EN = 1'b1;
        bus.start = 1'b0;
        bus.A = 32'd0;
        bus.B = 32'd0;
        repeat (3) @(negedge clk);
        check("reset OUT_ADD", bus.OUT_ADD, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        RST = 1'b0;

        // -2 + 1: one cancellation shift handled inside ADD.
        run_op(32'hC000_0000, 32'h3F80_0000, lat, bc);
        check("neg2+1 result", bus.OUT_ADD, 32'hBF80_0000);
        check("neg2+1 latency", 32'(lat), 32'd5);
        check("neg2+1 busy cycles", 32'(bc), 32'd5);
        @(negedge clk);
        check("neg2+1 done cleared", {31'd0, bus.done}, 32'd0);
        check("neg2+1 busy dropped", {31'd0, bus.busy}, 32'd0);

        // 6.4 - 0.5 with a second start mid-flight that must be ignored.
        restart_at = 2;
        run_op(32'h40CC_CCCC, 32'hBF00_0000, lat, bc);
        restart_at = -1;
        check("6.4-0.5 result", bus.OUT_ADD, 32'h40BC_CCCC);
        check("6.4-0.5 latency", 32'(lat), 32'd5);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        check("ignored start extra dones", 32'(extra), 32'd0);
        check("ignored start result held", bus.OUT_ADD, 32'h40BC_CCCC);

        // 1 - (1-2^-24): one shift in ADD, 23 in NORM.
        do_vec("near cancel", 32'h3F80_0000, 32'hBF7F_FFFF, 32'h3380_0000, 28);
        do_vec("inf-inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 2);
        do_vec("1-1", 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 5);
        do_vec("round case", 32'h3F80_0000, 32'h3380_0001, exp_rne, 5);
        do_vec("max+max", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 6);
        do_vec("nan+1", 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 2);
        do_vec("inf+1", 32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000, 2);
        do_vec("-0+-0", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 2);
        do_vec("1+0", 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000, 5);

        // EN low for three cycles stretches the latency by exactly three.
        en_at = 2;
        do_vec("en stall", 32'h40CC_CCCC, 32'hBF00_0000, 32'h40BC_CCCC, 8);
        en_at = -1;

        // Reset while normalizing aborts: no done afterwards.
        @(negedge clk);
        bus.A = 32'h3F80_0000;
        bus.B = 32'hBF7F_FFFF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-reset busy", {31'd0, bus.busy}, 32'd1);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort OUT_ADD", bus.OUT_ADD, 32'd0);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        check("abort no done", 32'(extra), 32'd0);

        // Carry-out path after recovery from reset.
        do_vec("1+1", 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
